// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: FFT size, sample width default, serializer FSM states and a helper
// that extracts one sample from a packed 8-sample word.
package ofdm_pkg;

  localparam int unsigned N_FFT            = 8;
  localparam int unsigned DEFAULT_SAMPLE_W = 16;
  localparam int unsigned MAX_SAMPLE_W     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCp,
    StData
  } state_e;

  // Word is zero-extended to the widest supported width; result bits above w are zero.
  function automatic logic [MAX_SAMPLE_W-1:0] get_sample(
    input logic [N_FFT*MAX_SAMPLE_W-1:0] word,
    input int unsigned                   w,
    input logic [2:0]                    k
  );
    logic [N_FFT*MAX_SAMPLE_W-1:0] sh;
    logic [MAX_SAMPLE_W-1:0]       mask;
    sh   = word >> (32'(k) * w);
    mask = '1;
    mask = mask >> (MAX_SAMPLE_W - w);
    return sh[MAX_SAMPLE_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/ofdm_sym_buf2.sv
// Two-entry symbol buffer: ACT feeds the serializer, NXT queues one symbol behind it.
module ofdm_sym_buf2 #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         act_load,
  input  logic         nxt_load,
  input  logic         promote,
  input  logic         act_clear,
  input  logic [W-1:0] in_phase,
  input  logic [W-1:0] in_quad,
  output logic [W-1:0] act_phase,
  output logic [W-1:0] act_quad,
  output logic [W-1:0] nxt_phase,
  output logic [W-1:0] nxt_quad,
  output logic         act_full,
  output logic         nxt_full
);

  logic [W-1:0] act_i_q, act_i_d, act_r_q, act_r_d;
  logic [W-1:0] nxt_i_q, nxt_i_d, nxt_r_q, nxt_r_d;
  logic         act_full_q, act_full_d, nxt_full_q, nxt_full_d;

  always_comb begin
    act_i_d    = act_i_q;
    act_r_d    = act_r_q;
    nxt_i_d    = nxt_i_q;
    nxt_r_d    = nxt_r_q;
    act_full_d = act_full_q;
    nxt_full_d = nxt_full_q;
    if (act_load) begin
      act_i_d    = in_phase;
      act_r_d    = in_quad;
      act_full_d = 1'b1;
    end else if (promote) begin
      act_i_d    = nxt_i_q;
      act_r_d    = nxt_r_q;
      act_full_d = 1'b1;
    end else if (act_clear) begin
      act_full_d = 1'b0;
    end
    if (nxt_load) begin
      nxt_i_d    = in_phase;
      nxt_r_d    = in_quad;
      nxt_full_d = 1'b1;
    end else if (promote) begin
      nxt_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_i_q    <= '0;
      act_r_q    <= '0;
      nxt_i_q    <= '0;
      nxt_r_q    <= '0;
      act_full_q <= 1'b0;
      nxt_full_q <= 1'b0;
    end else begin
      act_i_q    <= act_i_d;
      act_r_q    <= act_r_d;
      nxt_i_q    <= nxt_i_d;
      nxt_r_q    <= nxt_r_d;
      act_full_q <= act_full_d;
      nxt_full_q <= nxt_full_d;
    end
  end

  assign act_phase = act_i_q;
  assign act_quad  = act_r_q;
  assign nxt_phase = nxt_i_q;
  assign nxt_quad  = nxt_r_q;
  assign act_full  = act_full_q;
  assign nxt_full  = nxt_full_q;

endmodule

// File: rtl/ofdm_cp_serializer.sv
// Cyclic-prefix insertion and parallel-to-serial conversion of 8-sample OFDM symbols.
// Optional start/end-of-symbol flags are enabled with OFDM_CP_FLAGS_EN.
module ofdm_cp_serializer
  import ofdm_pkg::*;
#(
  parameter int unsigned CP_LEN   = 2,
  parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*SAMPLE_W-1:0] in_phase,
  input  logic [8*SAMPLE_W-1:0] in_quad,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SAMPLE_W-1:0]   out_i,
  output logic [SAMPLE_W-1:0]   out_q
`ifdef OFDM_CP_FLAGS_EN
  ,
  output logic                  out_sop,
  output logic                  out_eop
`endif
);

  localparam int unsigned WordW      = N_FFT * SAMPLE_W;
  localparam int unsigned ExtW       = N_FFT * MAX_SAMPLE_W;
  localparam logic [2:0]  StartIdx   = 3'(N_FFT - CP_LEN);
  localparam state_e      StartState = (CP_LEN == 0) ? StData : StCp;

  if (CP_LEN > 7 || SAMPLE_W == 0 || SAMPLE_W > MAX_SAMPLE_W) begin : g_bad_param
    $error("ofdm_cp_serializer: CP_LEN must be 0..7 and SAMPLE_W 1..32");
  end

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [SAMPLE_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic                sop_q, sop_d, eop_q, eop_d;

  logic                act_load, nxt_load, promote, act_clear, new_sym, reload;
  logic                act_full, nxt_full, in_xfer, out_xfer;
  logic [WordW-1:0]    act_phase, act_quad, nxt_phase, nxt_quad, src_i, src_q;
  logic [MAX_SAMPLE_W-1:0] samp_i, samp_q;

  assign in_ready = !nxt_full;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  ofdm_sym_buf2 #(
    .W (WordW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .act_load  (act_load),
    .nxt_load  (nxt_load),
    .promote   (promote),
    .act_clear (act_clear),
    .in_phase  (in_phase),
    .in_quad   (in_quad),
    .act_phase (act_phase),
    .act_quad  (act_quad),
    .nxt_phase (nxt_phase),
    .nxt_quad  (nxt_quad),
    .act_full  (act_full),
    .nxt_full  (nxt_full)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    act_load  = 1'b0;
    promote   = 1'b0;
    act_clear = 1'b0;
    new_sym   = 1'b0;
    reload    = 1'b0;
    src_i     = act_phase;
    src_q     = act_quad;
    samp_i    = '0;
    samp_q    = '0;

    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          act_load = 1'b1;
          new_sym  = 1'b1;
        end
      end
      StCp: begin
        if (out_xfer) begin
          reload = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = StData;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StData: begin
        if (out_xfer) begin
          if (idx_q == 3'd7) begin
            // End of symbol: queued symbol first, then a coincident input, else idle.
            if (nxt_full) begin
              promote = 1'b1;
              new_sym = 1'b1;
            end else if (in_xfer) begin
              act_load = 1'b1;
              new_sym  = 1'b1;
            end else begin
              state_d   = StIdle;
              valid_d   = 1'b0;
              act_clear = 1'b1;
              sop_d     = 1'b0;
              eop_d     = 1'b0;
            end
          end else begin
            reload = 1'b1;
            idx_d  = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (new_sym) begin
      state_d = StartState;
      idx_d   = StartIdx;
      valid_d = 1'b1;
      reload  = 1'b1;
    end

    // ACT is rewritten on this edge, so read the sample from the word being loaded.
    if (act_load) begin
      src_i = in_phase;
      src_q = in_quad;
    end else if (promote) begin
      src_i = nxt_phase;
      src_q = nxt_quad;
    end

    samp_i = get_sample(ExtW'(src_i), SAMPLE_W, idx_d);
    samp_q = get_sample(ExtW'(src_q), SAMPLE_W, idx_d);

    if (reload) begin
      out_i_d = samp_i[SAMPLE_W-1:0];
      out_q_d = samp_q[SAMPLE_W-1:0];
      sop_d   = new_sym;
      eop_d   = (state_d == StData) && (idx_d == 3'd7);
    end
  end

  assign nxt_load = in_xfer && act_full && !act_load;

  if (SAMPLE_W < MAX_SAMPLE_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^{samp_i[MAX_SAMPLE_W-1:SAMPLE_W], samp_q[MAX_SAMPLE_W-1:SAMPLE_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      out_i_q <= '0;
      out_q_q <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;

`ifdef OFDM_CP_FLAGS_EN
  assign out_sop = sop_q;
  assign out_eop = eop_q;
`else
  logic unused_flags;
  assign unused_flags = sop_q ^ eop_q;
`endif

endmodule

// File: tb/tb_ofdm_cp_serializer.sv
// Directed bench for ofdm_cp_serializer: CP_LEN=2 instance for the main tests plus a CP_LEN=0
// instance; flag outputs are checked when OFDM_CP_FLAGS_EN is defined.
module tb_ofdm_cp_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [127:0] a_in_phase, a_in_quad;
  logic [15:0]  a_out_i, a_out_q;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [127:0] b_in_phase, b_in_quad;
  logic [15:0]  b_out_i, b_out_q;
  logic         a_sop, a_eop, b_sop, b_eop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofdm_cp_serializer #(
    .CP_LEN   (2),
    .SAMPLE_W (16)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_phase  (a_in_phase),
    .in_quad   (a_in_quad),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
`ifdef OFDM_CP_FLAGS_EN
    .out_sop   (a_sop),
    .out_eop   (a_eop),
`endif
    .out_i     (a_out_i),
    .out_q     (a_out_q)
  );

  ofdm_cp_serializer #(
    .CP_LEN   (0),
    .SAMPLE_W (16)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_phase  (b_in_phase),
    .in_quad   (b_in_quad),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
`ifdef OFDM_CP_FLAGS_EN
    .out_sop   (b_sop),
    .out_eop   (b_eop),
`endif
    .out_i     (b_out_i),
    .out_q     (b_out_q)
  );

`ifndef OFDM_CP_FLAGS_EN
  assign a_sop = 1'b0;
  assign a_eop = 1'b0;
  assign b_sop = 1'b0;
  assign b_eop = 1'b0;
`endif

  // Symbol n: I sample k = 0x10*(n+1)+k, Q sample k = 0x8000+0x100*n+k.
  function automatic logic [127:0] pack_i(input int n);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(16 * (n + 1) + k);
    return w;
  endfunction

  function automatic logic [127:0] pack_q(input int n);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(32'h8000 + 256 * n + k);
    return w;
  endfunction

  // Sample index at output position pos for a prefix of length cp.
  function automatic int pos_idx(input int pos, input int cp);
    return (pos < cp) ? (8 - cp + pos) : (pos - cp);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input int n, input int pos);
    int k;
    k = pos_idx(pos, 2);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_i"}, 32'(a_out_i), 32'(16 * (n + 1) + k));
    chk({tag, "_q"}, 32'(a_out_q), 32'h8000 + 32'(256 * n + k));
`ifdef OFDM_CP_FLAGS_EN
    chk({tag, "_sop"}, 32'(a_sop), 32'(pos == 0));
    chk({tag, "_eop"}, 32'(a_eop), 32'(pos == 9));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] t1_i [10];
    logic [15:0] t1_q [10];
    int          sent;
    logic        acc;
    logic        saw_not_ready;

    t1_i = '{16'h0016, 16'h0017, 16'h0010, 16'h0011, 16'h0012,
             16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017};
    t1_q = '{16'h8006, 16'h8007, 16'h8000, 16'h8001, 16'h8002,
             16'h8003, 16'h8004, 16'h8005, 16'h8006, 16'h8007};

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    a_in_phase  = '0;
    a_in_quad   = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    b_in_phase  = '0;
    b_in_quad   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_i", 32'(a_out_i), 32'd0);
    chk("rst_q", 32'(a_out_q), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_valid_after", 32'(a_out_valid), 32'd0);

    // Single symbol, hand-computed sequence
    a_in_valid = 1'b1;
    a_in_phase = pack_i(0);
    a_in_quad  = pack_q(0);
    tick();
    a_in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("t1_valid_%0d", j), 32'(a_out_valid), 32'd1);
      chk($sformatf("t1_i_%0d", j), 32'(a_out_i), 32'(t1_i[j]));
      chk($sformatf("t1_q_%0d", j), 32'(a_out_q), 32'(t1_q[j]));
`ifdef OFDM_CP_FLAGS_EN
      chk($sformatf("t1_sop_%0d", j), 32'(a_sop), 32'(j == 0));
      chk($sformatf("t1_eop_%0d", j), 32'(a_eop), 32'(j == 9));
`endif
      tick();
    end
    chk("t1_idle", 32'(a_out_valid), 32'd0);

    // Three back-to-back symbols: 30 gap-free samples
    sent          = 0;
    saw_not_ready = 1'b0;
    a_in_valid    = 1'b1;
    a_in_phase    = pack_i(1);
    a_in_quad     = pack_q(1);
    for (int c = 0; c <= 30; c++) begin
      acc = a_in_valid && a_in_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent == 3) begin
          a_in_valid = 1'b0;
        end else begin
          a_in_phase = pack_i(1 + sent);
          a_in_quad  = pack_q(1 + sent);
        end
      end
      if (c < 30) exp_a($sformatf("b2b_%0d", c), 1 + c / 10, c % 10);
      else chk("b2b_idle", 32'(a_out_valid), 32'd0);
      if (!a_in_ready) saw_not_ready = 1'b1;
    end
    chk("b2b_sent", 32'(sent), 32'd3);
    chk("b2b_saw_not_ready", 32'(saw_not_ready), 32'd1);

    // out_ready toggling: every sample shown for two cycles, 20 cycles total
    a_in_valid = 1'b1;
    a_in_phase = pack_i(0);
    a_in_quad  = pack_q(0);
    tick();
    a_in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      exp_a($sformatf("stall_%0d", t), 0, t / 2);
      a_out_ready = (t % 2) == 1;
      tick();
    end
    chk("stall_idle", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b1;

    // Input transfer coincident with the DATA-7 transfer
    a_in_valid = 1'b1;
    a_in_phase = pack_i(0);
    a_in_quad  = pack_q(0);
    tick();
    a_in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      exp_a($sformatf("coin0_%0d", j), 0, j);
      if (j == 9) begin
        chk("coin_in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        a_in_phase = pack_i(1);
        a_in_quad  = pack_q(1);
      end
      tick();
    end
    a_in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      exp_a($sformatf("coin1_%0d", j), 1, j);
      tick();
    end
    chk("coin_idle", 32'(a_out_valid), 32'd0);

    // Reset at DATA index 4 with NXT full
    a_in_valid = 1'b1;
    a_in_phase = pack_i(0);
    a_in_quad  = pack_q(0);
    tick();
    a_in_phase = pack_i(1);
    a_in_quad  = pack_q(1);
    exp_a("mr_0", 0, 0);
    tick();
    a_in_valid = 1'b0;
    chk("mr_nxt_full", 32'(a_in_ready), 32'd0);
    for (int j = 1; j < 6; j++) begin
      exp_a($sformatf("mr_%0d", j), 0, j);
      tick();
    end
    exp_a("mr_6", 0, 6);
    rst_n = 1'b0;
    #1;
    chk("mr_valid_now", 32'(a_out_valid), 32'd0);
    chk("mr_in_ready_now", 32'(a_in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("mr_quiet_%0d", j), 32'(a_out_valid), 32'd0);
      chk($sformatf("mr_ready_%0d", j), 32'(a_in_ready), 32'd1);
    end
    a_in_valid = 1'b1;
    a_in_phase = pack_i(2);
    a_in_quad  = pack_q(2);
    tick();
    a_in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      exp_a($sformatf("mr_new_%0d", j), 2, j);
      tick();
    end
    chk("mr_new_idle", 32'(a_out_valid), 32'd0);

    // CP_LEN=0 instance: exactly samples 0..7
    b_in_valid = 1'b1;
    b_in_phase = pack_i(0);
    b_in_quad  = pack_q(0);
    tick();
    b_in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("cp0_valid_%0d", j), 32'(b_out_valid), 32'd1);
      chk($sformatf("cp0_i_%0d", j), 32'(b_out_i), 32'h10 + 32'(j));
      chk($sformatf("cp0_q_%0d", j), 32'(b_out_q), 32'h8000 + 32'(j));
`ifdef OFDM_CP_FLAGS_EN
      chk($sformatf("cp0_sop_%0d", j), 32'(b_sop), 32'(j == 0));
      chk($sformatf("cp0_eop_%0d", j), 32'(b_eop), 32'(j == 7));
`endif
      tick();
    end
    chk("cp0_idle", 32'(b_out_valid), 32'd0);
    chk("cp0_in_ready", 32'(b_in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
